misc_paddr_dispatch: RTL

- Sits directly after virtual-to-physical translation in the memory pipeline.
- Consumes the translated physical address and the kseg1 (uncached) attribute.
- Routes cached accesses to the data-cache port.
- Routes uncached accesses to the uncached bus port:
  - Uncached stores go through an in-order uncached store buffer (UCSB).
  - Uncached loads are issued only after the UCSB drains, and their response is returned to the pipeline.

---
 rtl/misc_defs.sv | 23 ++
 rtl/misc_ucsb_fifo.sv | 53 +++++
 rtl/misc_paddr_dispatch.sv | 132 +++++++++++++
 3 files changed

// File: rtl/misc_defs.sv
// misc_defs: shared definitions for the physical-address dispatch block.
//   fsm_e    : uncached-load sequencing states (IDLE, DRAIN, ISSUE, WAIT)
//   STRB_W   : byte-strobe width of a 32-bit access
//   uc_req_t : one uncached bus request {paddr, wen, wstrb, wdata}, 69 bits
package misc_defs;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } fsm_e;

  localparam int STRB_W = 4;

  typedef struct packed {
    logic [31:0]       paddr;
    logic              wen;
    logic [STRB_W-1:0] wstrb;
    logic [31:0]       wdata;
  } uc_req_t;

  localparam int UC_REQ_W = $bits(uc_req_t);
endpackage

// File: rtl/misc_ucsb_fifo.sv
// misc_ucsb_fifo: in-order uncached store buffer (synchronous FIFO).
//   clk, resetn : clock, async active-low reset (pointers/count only)
//   push, push_data : write tail; caller never pushes when full
//   pop         : retire head; caller never pops when empty
//   head        : current head entry (registered storage, so a pushed
//                 entry is visible no earlier than the following cycle)
//   full, empty, count : occupancy
module misc_ucsb_fifo
  import misc_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                push,
  input  logic [UC_REQ_W-1:0] push_data,
  input  logic                pop,
  output logic [UC_REQ_W-1:0] head,
  output logic                full,
  output logic                empty,
  output logic [PTR_W:0]      count
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [UC_REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
endmodule

// File: rtl/misc_paddr_dispatch.sv
// misc_paddr_dispatch: routes translated accesses after V->P translation.
//   Request in : i_valid/o_ready, i_paddr, i_kseg1 (1 = uncached), i_wen,
//                i_wstrb, i_wdata
//   Cached out : o_c_valid/i_c_ready, o_c_paddr/wen/wstrb/wdata (passthrough)
//   Uncached   : o_uc_valid/i_uc_ready, o_uc_paddr/wen/wstrb/wdata,
//                i_uc_rvalid/i_uc_rdata (load data)
//   Response   : o_rvalid (1-cycle pulse), o_rdata (held between pulses)
//   o_ucsb_empty : store buffer empty and no uncached load in flight
// Uncached stores queue in the UCSB; an uncached load waits for the UCSB to
// drain, then issues on the bus and returns its data to the pipeline.
module misc_paddr_dispatch
  import misc_defs::*;
#(
  parameter int UCSB_DEPTH = 4,
  parameter int UCSB_PTR_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_paddr,
  input  logic              i_kseg1,
  input  logic              i_wen,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [31:0]       i_wdata,
  output logic              o_c_valid,
  input  logic              i_c_ready,
  output logic [31:0]       o_c_paddr,
  output logic              o_c_wen,
  output logic [STRB_W-1:0] o_c_wstrb,
  output logic [31:0]       o_c_wdata,
  output logic              o_uc_valid,
  input  logic              i_uc_ready,
  output logic [31:0]       o_uc_paddr,
  output logic              o_uc_wen,
  output logic [STRB_W-1:0] o_uc_wstrb,
  output logic [31:0]       o_uc_wdata,
  input  logic              i_uc_rvalid,
  input  logic [31:0]       i_uc_rdata,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_ucsb_empty
);
  fsm_e               state;
  logic [31:0]        ld_addr;
  uc_req_t            head, push_req;
  logic               full, empty, push, pop, ld_acc, idle, head_vld;
  logic [UCSB_PTR_W:0] cnt;

  assign idle = (state == ST_IDLE);

  // New requests of any kind are only taken while no uncached load is active.
  always_comb begin
    o_ready = 1'b0;
    if (idle) begin
      if (!i_kseg1)   o_ready = i_c_ready;
      else if (i_wen) o_ready = ~full;
      else            o_ready = 1'b1;
    end
  end

  assign o_c_valid = i_valid & ~i_kseg1 & idle;
  assign o_c_paddr = i_paddr;
  assign o_c_wen   = i_wen;
  assign o_c_wstrb = i_wstrb;
  assign o_c_wdata = i_wdata;

  assign push   = i_valid & o_ready & i_kseg1 & i_wen;
  assign ld_acc = i_valid & o_ready & i_kseg1 & ~i_wen;

  assign push_req = '{paddr: i_paddr, wen: 1'b1, wstrb: i_wstrb, wdata: i_wdata};

  misc_ucsb_fifo #(.DEPTH(UCSB_DEPTH), .PTR_W(UCSB_PTR_W)) u_ucsb (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (cnt)
  );

  // UCSB owns the bus in IDLE/DRAIN; the load owns it in ISSUE. DRAIN only
  // exits with the UCSB empty, so the two never overlap.
  assign head_vld = (cnt != '0) & (idle | (state == ST_DRAIN));
  assign pop      = head_vld & i_uc_ready;

  always_comb begin
    o_uc_valid = head_vld;
    o_uc_paddr = head.paddr;
    o_uc_wen   = head.wen;
    o_uc_wstrb = head.wstrb;
    o_uc_wdata = head.wdata;
    if (state == ST_ISSUE) begin
      o_uc_valid = 1'b1;
      o_uc_paddr = ld_addr;
      o_uc_wen   = 1'b0;
      o_uc_wstrb = '0;
      o_uc_wdata = '0;
    end
  end

  // DRAIN is always entered for at least one cycle, even with an empty UCSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      ld_addr  <= '0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= 1'b0;
      case (state)
        ST_IDLE: if (ld_acc) begin
          ld_addr <= i_paddr;
          state   <= ST_DRAIN;
        end
        ST_DRAIN: if (cnt == '0) state <= ST_ISSUE;
        ST_ISSUE: if (i_uc_ready) state <= ST_WAIT;
        ST_WAIT: if (i_uc_rvalid) begin
          o_rdata  <= i_uc_rdata;
          o_rvalid <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ucsb_empty = empty & idle;
endmodule
